hasher_core: RTL and testbench

HASHER_CORE -- requirements
Module: hasher

---
 rtl/hasher_core.sv | 41 ++++
 tb/tb_hasher_core.sv | 116 +++++++++++
 2 files changed

// File: rtl/hasher_core.sv
// Registered 16-bit mixing hash: xor time, rotate, add key, multiply by K, xorshift.
// State is a single register cleared asynchronously by rst.
module hasher_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cur_time,
   input  logic [15:0] student_id,
   output logic [15:0] cur_hash
);

   localparam logic [15:0] K = 16'h9E37;

   logic [15:0] hash_q;
   logic [15:0] hash_d;
   logic [15:0] step_a;
   logic [15:0] step_b;
   logic [15:0] step_c;
   logic [31:0] product;
   logic [15:0] step_d;

   always_comb begin
      step_a  = hash_q ^ cur_time;
      step_b  = {step_a[10:0], step_a[15:11]};
      step_c  = step_b + student_id;
      // Full product computed, only the low half survives the mod 2^16 wrap.
      product = step_c * K;
      step_d  = product[15:0];
      hash_d  = step_d ^ (step_d >> 7);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hash_q <= 16'h0000;
      end else begin
         hash_q <= hash_d;
      end
   end

   assign cur_hash = hash_q;

endmodule

// File: tb/tb_hasher_core.sv
// Directed self-checking bench for hasher_core using hand-computed hash values.
module tb_hasher_core;

   logic        clk;
   logic        clk_en;
   logic        rst;
   logic [15:0] cur_time;
   logic [15:0] student_id;
   logic [15:0] cur_hash;

   int checks;
   int failures;

   hasher_core dut (
      .clk        (clk),
      .rst        (rst),
      .cur_time   (cur_time),
      .student_id (student_id),
      .cur_hash   (cur_hash)
   );

   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check_eq("reset_immediate", cur_hash, 16'h0000);
      rst = 1'b0;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      clk_en     = 1'b0;
      rst        = 1'b0;
      cur_time   = 16'h1234;
      student_id = 16'h5678;

      // Reset with the clock stopped must clear the state at once.
      #2;
      rst = 1'b1;
      #1;
      check_eq("reset_no_clock", cur_hash, 16'h0000);
      clk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("reset_held", cur_hash, 16'h0000);
      end
      rst = 1'b0;

      // Fixed point with all-zero inputs.
      cur_time   = 16'h0000;
      student_id = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("fixed_point", cur_hash, 16'h0000);
      end

      // Key chain.
      pulse_reset();
      student_id = 16'h0001;
      tick();
      check_eq("key_edge1", cur_hash, 16'h9F0B);
      tick();
      check_eq("key_edge2", cur_hash, 16'h07E3);

      // Mid-run reset discards state, chain restarts from zero.
      pulse_reset();
      tick();
      check_eq("midrun_edge1", cur_hash, 16'h9F0B);
      tick();
      check_eq("midrun_edge2", cur_hash, 16'h07E3);

      // Time input path.
      pulse_reset();
      cur_time   = 16'h0001;
      student_id = 16'h0000;
      tick();
      check_eq("time_edge1", cur_hash, 16'hC76D);

      // Glitching inputs between edges must neither move the state nor affect the result.
      pulse_reset();
      cur_time   = 16'h0000;
      student_id = 16'h0001;
      for (int i = 0; i < 2; i++) begin
         #2;
         cur_time   = 16'hFFFF;
         student_id = 16'hA5A5;
         #2;
         check_eq("between_edges_stable", cur_hash, (i == 0) ? 16'h0000 : 16'h9F0B);
         cur_time   = 16'h0000;
         student_id = 16'h0001;
         tick();
         check_eq("glitch_result", cur_hash, (i == 0) ? 16'h9F0B : 16'h07E3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
